shift_add_mult: RTL and testbench
=================================

// Module: shift_add_mult
// PURPOSE
//  Iterative unsigned shift-add multiplier. Downstream consumer of the 4-bit CLA: one
//  N-bit adder built from chained cla4b slices is reused once per cycle for N cycles.
//  Execute-stage multi-cycle unit: the pipeline stalls while busy and captures product on done.
//  Start/busy/done handshake; one multiply in flight.
// PARAMETERS
//  N      16  operand width; must be a multiple of 4 (adder built from 4-bit CLA slices)
//  CNT_W  5   step-counter width; must satisfy 2**CNT_W > N
// PORTS
//  clk      in   1     clock; all state updates on rising edge
//  rst      in   1     synchronous, active-high reset
//  start    in   1     request; sampled only in IDLE or DONE
//  a        in   N     multiplicand; sampled on accepted start
//  b        in   N     multiplier; sampled on accepted start
//  busy     out  1     high while in RUN
//  done     out  1     one-cycle pulse; product valid
//  product  out  2N    {acc, q}; valid from done until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, q=0, m=0, cnt=0; busy=0, done=0, product=0 in the cycle after rst.
//  rst overrides all inputs, including a start in the same cycle.
//  States (registered):
//   IDLE: start=1 -> load m<=a, q<=b, acc<=0, cnt<=N; go RUN. start=0 -> stay.
//   RUN:  one step per edge:
//         {c,s} = acc + (q[0] ? m : 0), computed through the CLA adder with cIn=0;
//         {acc,q} <= {c,s,q} >> 1, i.e. acc<={c,s[N-1:1]}, q<={s[0],q[N-1:1]}; cnt<=cnt-1.
//         On the step with cnt==1 -> go DONE. start is ignored in RUN.
//   DONE: done=1 for exactly this cycle. start=1 -> same load as IDLE, go RUN (back-to-back).
//         start=0 -> go IDLE.
//  Latency: start accepted at edge E0; N steps at E1..EN; done high in the cycle after EN.
//   For N=16, done is high 17 cycles after the accept edge.
//   Throughput: one result every N+1 cycles with back-to-back starts.
//  Outputs are pure decodes of registers; no combinational path from inputs to outputs.
//   busy = (state==RUN); done = (state==DONE).
//  product = {acc,q} at all times. It holds the final value through DONE and IDLE.
//   It changes only on an accepted start, on RUN steps, or on rst.
//  Width rules: the adder carry-out becomes acc MSB on shift; no overflow is possible.
//   The full 2N-bit result is exact (max (2^N-1)^2 < 2^2N).
//  a and b may change freely after the accept edge; internal copies are used.
//  Reset mid-RUN aborts the operation: back to IDLE, product=0, no done pulse.
//  Illegal state encoding -> IDLE on the next edge.
// STRUCTURE
//  Shared include mult_defs.vh: state localparams (ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10)
//   and the default width constants.
//  Sub-module cla_nb: N-bit adder built from N/4 rippled cla4b slices.
//   Ports sum[N-1:0], cOut, inA, inB, cIn. Instantiated once, combinational.
//  Operand gating (q[0] ? m : 0) is done with and2 gates before the adder.
//  State, counter and data registers use the codebase dff cell with synchronous rst.
// TESTING
//  1 a=16'hFFFF, b=16'hFFFF, start 1 cycle -> busy 16 cycles; done in cycle 17;
//    product=32'hFFFE_0001.
//  2 a=3, b=5 -> product=32'h0000_000F. a=0, b=16'h1234 -> product=0; done timing unchanged.
//  3 Start pulsed again mid-RUN with a=7, b=7 -> ignored; first result completes unaltered
//    and only one done pulse occurs.
//  4 rst asserted at step 8 of a=16'h8000, b=2 -> next cycle: busy=0, product=0,
//    no done; a new start then gives 32'h0001_0000.
//  5 Back-to-back: start held high through DONE with a=2, b=16'h8001 -> second run
//    begins with no IDLE cycle; second done 17 cycles after the first;
//    product=32'h0001_0002.
//  6 Random regression of 10k pairs vs a*b reference model.
//    Assert done is a 1-cycle pulse, busy and done are never both high,
//    and product is stable between done and the next start.

Source files
------------

// File: rtl/shift_add_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier:
// state encoding, default widths and the 4-bit carry-lookahead slice.
package shift_add_mult_pkg;

    localparam int DEFAULT_N     = 16;
    localparam int DEFAULT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mult_state_t;

    // One 4-bit carry-lookahead slice; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4b(input logic [3:0] in_a,
                                         input logic [3:0] in_b,
                                         input logic       c_in);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = in_a & in_b;
        p    = in_a ^ in_b;
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

endpackage

// File: rtl/shift_add_mult_cla_nb.sv
// N-bit combinational adder built from N/4 carry-lookahead slices whose
// carries ripple from one slice to the next.
import shift_add_mult_pkg::*;

module shift_add_mult_cla_nb #(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         cIn,
    output logic [N-1:0] sum,
    output logic         cOut
);

    logic [N/4:0] carry;

    assign carry[0] = cIn;

    for (genvar i = 0; i < N / 4; i++) begin : g_slice
        logic [4:0] slice_out;
        assign slice_out      = cla4b(inA[4*i +: 4], inB[4*i +: 4], carry[i]);
        assign sum[4*i +: 4]  = slice_out[3:0];
        assign carry[i+1]     = slice_out[4];
    end

    assign cOut = carry[N/4];

endmodule

// File: rtl/shift_add_mult.sv
// Iterative unsigned shift-add multiplier: one shared N-bit adder is reused for
// N steps, with a start/busy/done handshake and one operation in flight.
import shift_add_mult_pkg::*;

module shift_add_mult #(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    mult_state_t      state;
    mult_state_t      state_next;
    logic [N-1:0]     acc;
    logic [N-1:0]     q;
    logic [N-1:0]     m;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic [N-1:0]     addend;
    logic [N-1:0]     sum;
    logic             c_out;

    // Partial-product gating: the multiplicand only enters the adder when q[0] is set.
    assign addend = m & {N{q[0]}};

    shift_add_mult_cla_nb #(.N(N)) u_adder (
        .inA  (acc),
        .inB  (addend),
        .cIn  (1'b0),
        .sum  (sum),
        .cOut (c_out)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Each RUN step shifts {carry, sum, q} right by one; the carry-out lands in acc's MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                m   <= a;
                q   <= b;
                acc <= '0;
                cnt <= CNT_W'(N);
            end else if (step) begin
                acc <= {c_out, sum[N-1:1]};
                q   <= {sum[0], q[N-1:1]};
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy    = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign product = {acc, q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and small random checks for shift_add_mult: table of operand pairs,
// plus hand-written sequences for abort, ignored start and back-to-back runs.
module tb_shift_add_mult;

    localparam int N = 16;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] expected;
    } vector_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int failures;

    shift_add_mult #(.N(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Launch one multiply and wait for done; operands are scrambled after acceptance.
    task automatic applyStimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                                 output logic [31:0] result, output int edges,
                                 output int busy_cycles);
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(negedge clk);
        start       = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy && done) checkOutput("busy_done_overlap", 1, 0);
            if (busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        result = product;
    endtask

    vector_t     vectors[10];
    logic [31:0] result;
    logic [31:0] held;
    int          edges;
    int          busy_cycles;
    int          done_count;
    int          first_done;

    initial begin
        checks   = 0;
        failures = 0;
        vectors[0] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vectors[1] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vectors[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vectors[3] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vectors[4] = '{16'h0002, 16'h8001, 32'h0001_0002};
        vectors[5] = '{16'h0001, 16'h0001, 32'h0000_0001};
        vectors[6] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vectors[7] = '{16'hABCD, 16'h1234, 32'h0C37_4FA4};
        vectors[8] = '{16'h8000, 16'h8000, 32'h4000_0000};
        vectors[9] = '{16'hFFFF, 16'h8000, 32'h7FFF_8000};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 0);
        checkOutput("reset_done", 64'(done), 0);
        checkOutput("reset_product", 64'(product), 0);

        // A start coinciding with reset must be dropped.
        start = 1'b1;
        a     = 16'h0003;
        b     = 16'h0003;
        @(negedge clk);
        checkOutput("rst_overrides_start", 64'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, result, edges, busy_cycles);
            checkOutput($sformatf("vec%0d_product", i), 64'(result), 64'(vectors[i].expected));
            checkOutput($sformatf("vec%0d_latency", i), 64'(edges), 16);
            checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(busy_cycles), 16);
            repeat (2) begin
                @(negedge clk);
                checkOutput($sformatf("vec%0d_done_pulse", i), 64'(done), 0);
                checkOutput($sformatf("vec%0d_product_hold", i), 64'(product),
                            64'(vectors[i].expected));
            end
        end

        // A second start during RUN is ignored and yields a single done pulse.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h0005;
        b     = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1;
        a     = 16'h0007;
        b     = 16'h0007;
        @(negedge clk);
        start      = 1'b0;
        done_count = 0;
        held       = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                done_count++;
                held = product;
            end
            @(negedge clk);
        end
        checkOutput("ignored_start_done_count", 64'(done_count), 1);
        checkOutput("ignored_start_product", 64'(held), 64'h0000_000F);
        checkOutput("ignored_start_idle_product", 64'(product), 64'h0000_000F);

        // Reset partway through a run aborts it with no done pulse.
        start = 1'b1;
        a     = 16'h8000;
        b     = 16'h0002;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy), 0);
        checkOutput("abort_done", 64'(done), 0);
        checkOutput("abort_product", 64'(product), 0);
        done_count = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) done_count++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 64'(done_count), 0);
        applyStimulus(16'h8000, 16'h0002, result, edges, busy_cycles);
        checkOutput("after_abort_product", 64'(result), 64'h0001_0000);

        // Back-to-back: start held through DONE restarts without an IDLE cycle.
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 16'h0002;
        b     = 16'h8001;
        @(negedge clk);
        edges = 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        first_done = edges;
        checkOutput("b2b_first_latency", 64'(first_done), 16);
        checkOutput("b2b_first_product", 64'(product), 64'h0001_0002);
        @(negedge clk);
        edges++;
        checkOutput("b2b_no_idle_gap", 64'(busy), 1);
        start = 1'b0;
        while (!done && edges < 80) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("b2b_second_gap", 64'(edges - first_done), 17);
        checkOutput("b2b_second_product", 64'(product), 64'h0001_0002);
        @(negedge clk);

        // Random pairs against a plain multiply.
        for (int i = 0; i < 200; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [31:0] expected;
            ra       = 16'($urandom);
            rb       = 16'($urandom);
            expected = 32'(ra) * 32'(rb);
            applyStimulus(ra, rb, result, edges, busy_cycles);
            checkOutput($sformatf("rand%0d_%0h_x_%0h", i, ra, rb), 64'(result), 64'(expected));
            checkOutput($sformatf("rand%0d_latency", i), 64'(edges), 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
